// File: rtl/fullconnect_pkg.sv
// ============================================================================
// Module      : fullconnect_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               fully-connected multiply-accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fullconnect_pkg;

    localparam int LANES      = 64;
    localparam int LANE_W     = 8;
    localparam int PROD_W     = 16;
    localparam int ACC_W      = 32;
    localparam int PIPE_DEPTH = 4;
    localparam int TREE_GROW  = 6;
    localparam int SUM_W      = PROD_W + TREE_GROW;
    localparam int HEIGHT_W   = 9;
    localparam int CNT_W      = HEIGHT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Number of beat pairs a neuron expects: Height is stored minus one.
    function automatic logic [CNT_W-1:0] pairTarget(input logic [HEIGHT_W-1:0] height);
        return {1'b0, height} + CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fullconnect_addtree.sv
// ============================================================================
// Module      : fullconnect_addtree
// Description : Three-stage registered signed adder tree reducing 64 products
//               to one sum (4 -> 1 per stage), with a valid bit in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullconnect_addtree
    import fullconnect_pkg::*;
#(
    parameter int IN_W = PROD_W
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [LANES*IN_W-1:0]  i_prods,
    output logic                   o_valid,
    output logic                   o_pending,
    output logic signed [IN_W+5:0] o_sum
);

    localparam int c_S2_W = IN_W + 2;
    localparam int c_S3_W = IN_W + 4;
    localparam int c_S4_W = IN_W + 6;
    localparam int c_N2   = LANES / 4;
    localparam int c_N3   = LANES / 16;

    logic signed [c_S2_W-1:0] w_in  [LANES];
    logic signed [c_S2_W-1:0] r_s2  [c_N2];
    logic signed [c_S3_W-1:0] w_s2x [c_N2];
    logic signed [c_S3_W-1:0] r_s3  [c_N3];
    logic signed [c_S4_W-1:0] w_s3x [c_N3];
    logic signed [c_S4_W-1:0] r_s4;
    logic                     r_v2;
    logic                     r_v3;
    logic                     r_v4;

    // Each level is sign-extended by two bits so four operands never overflow.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_inExt
            assign w_in[gi] = {{2{i_prods[gi*IN_W+IN_W-1]}}, i_prods[gi*IN_W +: IN_W]};
        end
        for (genvar gj = 0; gj < c_N2; gj++) begin : g_s2Ext
            assign w_s2x[gj] = {{2{r_s2[gj][c_S2_W-1]}}, r_s2[gj]};
        end
        for (genvar gk = 0; gk < c_N3; gk++) begin : g_s3Ext
            assign w_s3x[gk] = {{2{r_s3[gk][c_S3_W-1]}}, r_s3[gk]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_valid) begin
            for (int j = 0; j < c_N2; j++) begin
                r_s2[j] <= w_in[4*j] + w_in[4*j+1] + w_in[4*j+2] + w_in[4*j+3];
            end
        end
        if (r_v2) begin
            for (int k = 0; k < c_N3; k++) begin
                r_s3[k] <= w_s2x[4*k] + w_s2x[4*k+1] + w_s2x[4*k+2] + w_s2x[4*k+3];
            end
        end
        if (r_v3) begin
            r_s4 <= w_s3x[0] + w_s3x[1] + w_s3x[2] + w_s3x[3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else begin
            r_v2 <= i_valid;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    assign o_valid   = r_v4;
    assign o_pending = r_v2 | r_v3 | r_v4;
    assign o_sum     = r_s4;

endmodule

`default_nettype wire

// File: rtl/fullconnect_mulac.sv
// ============================================================================
// Module      : fullconnect_mulac
// Description : Lane-wise 8x8 signed multiply, pipelined adder tree and
//               per-neuron accumulator. Optional ReLU on the result when
//               FULLCONNECT_MULAC_RELU_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullconnect_mulac #(
    parameter int DATA_WIDTH = 512,
    parameter int LANE_W     = 8,
    parameter int ACC_W      = 32
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Start_i,
    input  logic [8:0]              Height_i,
    input  logic                    WgtValid_i,
    input  logic                    DataValid_i,
    input  logic                    DataDone_i,
    input  logic [DATA_WIDTH-1:0]   Weight_i,
    input  logic [DATA_WIDTH-1:0]   Data_i,
    output logic signed [ACC_W-1:0] Result_o,
    output logic                    ResultValid_o,
    output logic                    Busy_o,
    output logic                    Err_o
);

    import fullconnect_pkg::*;

    localparam int c_PROD_W = 2 * LANE_W;
    localparam int c_SUM_W  = c_PROD_W + TREE_GROW;

    state_t                      r_state;
    logic [DATA_WIDTH-1:0]       r_wgt;
    logic                        r_wgtHeld;
    logic [CNT_W-1:0]            r_count;
    logic [HEIGHT_W-1:0]         r_height;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     r_result;
    logic signed [ACC_W-1:0]     w_resultNext;
    logic                        r_resultValid;
    logic                        r_busy;
    logic                        r_err;
    logic [LANES*c_PROD_W-1:0]   w_prods;
    logic [LANES*c_PROD_W-1:0]   r_prods;
    logic                        r_s1Valid;
    logic                        w_launch;
    logic                        w_treeValid;
    logic                        w_treePending;
    logic signed [c_SUM_W-1:0]   w_treeSum;
    logic                        w_pipeEmpty;

    assign w_launch    = (r_state == ST_ACC) && DataValid_i && r_wgtHeld;
    assign w_pipeEmpty = !r_s1Valid && !w_treePending;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [c_PROD_W-1:0] w_a;
            logic signed [c_PROD_W-1:0] w_b;
            assign w_a = {{LANE_W{r_wgt[gi*LANE_W+LANE_W-1]}}, r_wgt[gi*LANE_W +: LANE_W]};
            assign w_b = {{LANE_W{Data_i[gi*LANE_W+LANE_W-1]}}, Data_i[gi*LANE_W +: LANE_W]};
            assign w_prods[gi*c_PROD_W +: c_PROD_W] = w_a * w_b;
        end
    endgenerate

    // Stage 1: registered products, launched only for accepted pairs.
    always_ff @(posedge clk) begin
        if (rst || Start_i) begin
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= w_launch;
        end
        if (w_launch) begin
            r_prods <= w_prods;
        end
    end

    fullconnect_addtree #(
        .IN_W      (c_PROD_W)
    ) u_addtree (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (Start_i),
        .i_valid   (r_s1Valid),
        .i_prods   (r_prods),
        .o_valid   (w_treeValid),
        .o_pending (w_treePending),
        .o_sum     (w_treeSum)
    );

    always_ff @(posedge clk) begin
        if (rst || Start_i) begin
            r_acc <= '0;
        end else if (w_treeValid) begin
            r_acc <= r_acc + {{(ACC_W-c_SUM_W){w_treeSum[c_SUM_W-1]}}, w_treeSum};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !Start_i && (r_state == ST_ACC) && WgtValid_i) begin
            r_wgt <= Weight_i;
        end
    end

`ifdef FULLCONNECT_MULAC_RELU_EN
    assign w_resultNext = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign w_resultNext = r_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wgtHeld     <= 1'b0;
            r_count       <= '0;
            r_height      <= '0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else if (Start_i) begin
            r_state       <= ST_ACC;
            r_wgtHeld     <= 1'b0;
            r_count       <= '0;
            r_height      <= Height_i;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_busy        <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (DataValid_i) begin
                        if (r_wgtHeld) begin
                            r_wgtHeld <= 1'b0;
                            r_count   <= r_count + CNT_W'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    // A same-cycle data beat consumes the old weight, so only
                    // a weight arriving onto an unconsumed one is an overwrite.
                    if (WgtValid_i) begin
                        r_wgtHeld <= 1'b1;
                        if (r_wgtHeld && !DataValid_i) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (DataDone_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipeEmpty) begin
                        r_state       <= ST_OUT;
                        r_result      <= w_resultNext;
                        r_resultValid <= 1'b1;
                        r_busy        <= 1'b0;
                        if (r_count != pairTarget(r_height)) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    r_state       <= ST_IDLE;
                    r_resultValid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Result_o      = r_result;
    assign ResultValid_o = r_resultValid;
    assign Busy_o        = r_busy;
    assign Err_o         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fullconnect_mulac.sv
// ============================================================================
// Module      : tb_fullconnect_mulac
// Description : Directed table-driven bench for fullconnect_mulac; expected
//               results follow FULLCONNECT_MULAC_RELU_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fullconnect_mulac;

    logic               clk = 1'b0;
    logic               rst;
    logic               Start_i;
    logic [8:0]         Height_i;
    logic               WgtValid_i;
    logic               DataValid_i;
    logic               DataDone_i;
    logic [511:0]       Weight_i;
    logic [511:0]       Data_i;
    logic signed [31:0] Result_o;
    logic               ResultValid_o;
    logic               Busy_o;
    logic               Err_o;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    fullconnect_mulac u_dut (
        .clk           (clk),
        .rst           (rst),
        .Start_i       (Start_i),
        .Height_i      (Height_i),
        .WgtValid_i    (WgtValid_i),
        .DataValid_i   (DataValid_i),
        .DataDone_i    (DataDone_i),
        .Weight_i      (Weight_i),
        .Data_i        (Data_i),
        .Result_o      (Result_o),
        .ResultValid_o (ResultValid_o),
        .Busy_o        (Busy_o),
        .Err_o         (Err_o)
    );

    typedef struct {
        logic [8:0] height;
        int         pairs;
        int         wE;
        int         wO;
        int         dE;
        int         dO;
        int         expRaw;
        bit         expErr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual %0d (0x%08h) required %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [511:0] mkBeat(input logic [7:0] e, input logic [7:0] o);
        logic [511:0] b;
        for (int i = 0; i < 64; i++) b[i*8 +: 8] = (i % 2 == 0) ? e : o;
        return b;
    endfunction

    function automatic int relu(input int v);
`ifdef FULLCONNECT_MULAC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic startVec(input logic [8:0] h);
        Start_i  = 1'b1;
        Height_i = h;
        @(negedge clk);
        Start_i  = 1'b0;
    endtask

    task automatic sendWgt(input logic [511:0] w);
        WgtValid_i = 1'b1;
        Weight_i   = w;
        @(negedge clk);
        WgtValid_i = 1'b0;
    endtask

    task automatic sendData(input logic [511:0] d, input logic done);
        DataValid_i = 1'b1;
        DataDone_i  = done;
        Data_i      = d;
        @(negedge clk);
        DataValid_i = 1'b0;
        DataDone_i  = 1'b0;
    endtask

    // Cycles counted from the final data beat; gives up after 30.
    task automatic waitResult(input string name, output int lat);
        lat = 1;
        while (!ResultValid_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!ResultValid_o) check({name, " resultValid timeout"}, 32'(ResultValid_o), 32'd1);
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (ResultValid_o) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vecs[0] = '{9'd0,   1,    1,    1,    1,   1,        64, 1'b0};
        vecs[1] = '{9'd511, 512, -128, -128, -128, -128, 536870912, 1'b0};
        vecs[2] = '{9'd3,   4,    3,   -3,    5,   5,         0, 1'b0};
        vecs[3] = '{9'd3,   4,   -3,   -3,    5,   5,     -3840, 1'b0};
        vecs[4] = '{9'd1,   2,    7,   -2,   -4,   9,     -2944, 1'b0};
        vecs[5] = '{9'd0,   1,  127,  127,  127, 127,   1032256, 1'b0};
        vecs[6] = '{9'd0,   1, -128, -128,  127, 127,  -1040384, 1'b0};
        vecs[7] = '{9'd2,   1,    1,    1,    1,   1,        64, 1'b1};
        vecs[8] = '{9'd0,   2,    1,    1,    1,   1,       128, 1'b1};

        rst = 1'b1; Start_i = 1'b0; Height_i = '0;
        WgtValid_i = 1'b0; DataValid_i = 1'b0; DataDone_i = 1'b0;
        Weight_i = '0; Data_i = '0;
        repeat (3) @(negedge clk);
        check("reset Result_o", Result_o, 32'd0);
        check("reset ResultValid_o", 32'(ResultValid_o), 32'd0);
        check("reset Busy_o", 32'(Busy_o), 32'd0);
        check("reset Err_o", 32'(Err_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            startVec(vecs[v].height);
            check($sformatf("v%0d busy after start", v), 32'(Busy_o), 32'd1);
            for (int p = 0; p < vecs[v].pairs; p++) begin
                sendWgt(mkBeat(8'(vecs[v].wE), 8'(vecs[v].wO)));
                sendData(mkBeat(8'(vecs[v].dE), 8'(vecs[v].dO)), p == vecs[v].pairs - 1);
            end
            waitResult($sformatf("v%0d", v), lat);
            check($sformatf("v%0d latency", v), 32'(lat), 32'd6);
            check($sformatf("v%0d result", v), Result_o, 32'(relu(vecs[v].expRaw)));
            check($sformatf("v%0d err", v), 32'(Err_o), 32'(vecs[v].expErr));
            check($sformatf("v%0d busy at result", v), 32'(Busy_o), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d single pulse", v), 32'(ResultValid_o), 32'd0);
            check($sformatf("v%0d result held", v), Result_o, 32'(relu(vecs[v].expRaw)));
        end

        // Data beat with no weight held is dropped and flags an error.
        startVec(9'd1);
        sendData(mkBeat(8'd4, 8'd4), 1'b0);
        check("drop err sticky", 32'(Err_o), 32'd1);
        for (int p = 0; p < 2; p++) begin
            sendWgt(mkBeat(8'd1, 8'd1));
            sendData(mkBeat(8'd1, 8'd1), p == 1);
        end
        waitResult("drop", lat);
        check("drop latency", 32'(lat), 32'd6);
        check("drop result", Result_o, 32'd128);
        check("drop err", 32'(Err_o), 32'd1);
        @(negedge clk);

        // Second weight without a data beat overwrites the first.
        startVec(9'd0);
        sendWgt(mkBeat(8'd9, 8'd9));
        sendWgt(mkBeat(8'd2, 8'd2));
        check("overwrite err", 32'(Err_o), 32'd1);
        sendData(mkBeat(8'd3, 8'd3), 1'b1);
        waitResult("overwrite", lat);
        check("overwrite result", Result_o, 32'd384);
        @(negedge clk);

        // Restart during DRAIN discards the in-flight result.
        startVec(9'd0);
        sendWgt(mkBeat(8'd5, 8'd5));
        sendData(mkBeat(8'd5, 8'd5), 1'b1);
        @(negedge clk);
        startVec(9'd0);
        check("restart Result_o cleared", Result_o, 32'd0);
        check("restart err cleared", 32'(Err_o), 32'd0);
        countPulses(10, pulses);
        check("restart no pulse", 32'(pulses), 32'd0);
        check("restart busy", 32'(Busy_o), 32'd1);
        sendWgt(mkBeat(8'd1, 8'd1));
        sendData(mkBeat(8'd2, 8'd2), 1'b1);
        waitResult("restart", lat);
        check("restart latency", 32'(lat), 32'd6);
        check("restart result from zero", Result_o, 32'd128);
        check("restart err", 32'(Err_o), 32'd0);
        @(negedge clk);

        // Reset mid-accumulation, then valids must be ignored until Start_i.
        startVec(9'd0);
        sendData(mkBeat(8'd1, 8'd1), 1'b0);
        sendWgt(mkBeat(8'd1, 8'd1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst Result_o", Result_o, 32'd0);
        check("rst ResultValid_o", 32'(ResultValid_o), 32'd0);
        check("rst Busy_o", 32'(Busy_o), 32'd0);
        check("rst Err_o", 32'(Err_o), 32'd0);
        sendWgt(mkBeat(8'd1, 8'd1));
        sendData(mkBeat(8'd1, 8'd1), 1'b1);
        countPulses(10, pulses);
        check("rst ignores valids", 32'(pulses), 32'd0);
        check("rst idle busy", 32'(Busy_o), 32'd0);
        check("rst idle err", 32'(Err_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
